// File: rtl/aes128_ctr_sched.sv
// CTR-mode sequencer for a shared aes128 core: drives nonce||counter blocks
// into the core, captures the keystream and XORs it with streamed plaintext.
module aes128_ctr_sched #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BLK_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 pi_clk,
  input  logic                 pi_rst_n,
  input  logic                 pi_cfg_valid,
  output logic                 po_cfg_ready,
  input  logic [127:0]         pi_key,
  input  logic [127-CNT_W:0]   pi_nonce,
  input  logic [CNT_W-1:0]     pi_cnt_init,
  input  logic [BLK_W-1:0]     pi_num_blk,
  input  logic                 pi_in_valid,
  output logic                 po_in_ready,
  input  logic [127:0]         pi_in_data,
  output logic                 po_out_valid,
  input  logic                 pi_out_ready,
  output logic [127:0]         po_out_data,
  output logic                 po_aes_start,
  output logic [127:0]         po_aes_key,
  output logic [127:0]         po_aes_data,
  input  logic                 pi_aes_done,
  input  logic [127:0]         pi_aes_out,
  output logic                 po_busy,
  output logic                 po_msg_done,
  output logic [1:0]           po_err
);

  localparam int unsigned NONCE_W = 128 - CNT_W;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;

  logic [NONCE_W-1:0] nonce;
  logic [CNT_W-1:0]   cnt;
  logic [BLK_W-1:0]   remaining;
  logic [127:0]       keystream;
  logic [TMO_W-1:0]   tmo_cnt;

  logic ld_cfg;
  logic ks_ld;
  logic in_fire;
  logic out_fire;
  logic tmo_fire;
  logic last_blk;
  logic cnt_max;
  logic msg_end;

  logic cfg_ready_d;
  logic busy_d;
  logic in_ready_d;
  logic out_valid_d;
  logic start_d;
  logic msg_done_d;

  // Transaction events decoded from the current state and handshakes
  assign ld_cfg   = (state == S_IDLE) && pi_cfg_valid;
  assign ks_ld    = (state == S_WAIT) && pi_aes_done;
  assign in_fire  = (state == S_DATA) && pi_in_valid;
  assign out_fire = (state == S_OUT)  && pi_out_ready;
  assign tmo_fire = (state == S_WAIT) && !pi_aes_done &&
                    (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign last_blk = (remaining == BLK_W'(1));
  assign cnt_max  = (cnt == {CNT_W{1'b1}});
  assign msg_end  = tmo_fire || (out_fire && (last_blk || cnt_max));

  // State register
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) state <= S_IDLE;
    else           state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (ld_cfg) next_state = S_GEN;
      S_GEN:  next_state = S_WAIT;
      S_WAIT: begin
        if (ks_ld)         next_state = S_DATA;
        else if (tmo_fire) next_state = S_IDLE;
      end
      S_DATA: if (in_fire) next_state = S_OUT;
      S_OUT: begin
        if (out_fire) next_state = (last_blk || cnt_max) ? S_IDLE : S_GEN;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs, aligned with next_state
  always_comb begin
    cfg_ready_d = 1'b0;
    busy_d      = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    start_d     = 1'b0;
    msg_done_d  = msg_end;
    case (next_state)
      S_IDLE:  cfg_ready_d = 1'b1;
      S_GEN:   begin busy_d = 1'b1; start_d = 1'b1; end
      S_DATA:  begin busy_d = 1'b1; in_ready_d = 1'b1; end
      S_OUT:   begin busy_d = 1'b1; out_valid_d = 1'b1; end
      default: busy_d = 1'b1;
    endcase
  end

  // Control output registers
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      po_cfg_ready <= 1'b1;
      po_busy      <= 1'b0;
      po_in_ready  <= 1'b0;
      po_out_valid <= 1'b0;
      po_aes_start <= 1'b0;
      po_msg_done  <= 1'b0;
    end else begin
      po_cfg_ready <= cfg_ready_d;
      po_busy      <= busy_d;
      po_in_ready  <= in_ready_d;
      po_out_valid <= out_valid_d;
      po_aes_start <= start_d;
      po_msg_done  <= msg_done_d;
    end
  end

  // Message context: key, nonce, counter, block count and core data word
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      po_aes_key  <= '0;
      po_aes_data <= '0;
      nonce       <= '0;
      cnt         <= '0;
      remaining   <= '0;
    end else if (ld_cfg) begin
      po_aes_key  <= pi_key;
      po_aes_data <= {pi_nonce, pi_cnt_init};
      nonce       <= pi_nonce;
      cnt         <= pi_cnt_init;
      remaining   <= (pi_num_blk == '0) ? BLK_W'(1) : pi_num_blk;
    end else if (out_fire) begin
      remaining <= remaining - BLK_W'(1);
      // Counter only advances when another block will actually be generated
      if (!last_blk && !cnt_max) begin
        cnt         <= cnt + CNT_W'(1);
        po_aes_data <= {nonce, cnt + CNT_W'(1)};
      end
    end
  end

  // Keystream capture and ciphertext register
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      keystream   <= '0;
      po_out_data <= '0;
    end else begin
      if (ks_ld)   keystream   <= pi_aes_out;
      if (in_fire) po_out_data <= pi_in_data ^ keystream;
    end
  end

  // Core-response watchdog, counts cycles spent in WAIT
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n)            tmo_cnt <= '0;
    else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                      tmo_cnt <= '0;
  end

  // Sticky error flags, cleared when a new message is accepted
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      po_err <= 2'b00;
    end else if (ld_cfg) begin
      po_err <= 2'b00;
    end else begin
      if (out_fire && !last_blk && cnt_max) po_err[0] <= 1'b1;
      if (tmo_fire)                         po_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes128_ctr_sched.sv
// Directed bench for aes128_ctr_sched with a behavioural core model and a
// ciphertext scoreboard.
module tb_aes128_ctr_sched;

  logic         pi_clk = 1'b0;
  logic         pi_rst_n = 1'b1;
  logic         pi_cfg_valid = 1'b0;
  logic         po_cfg_ready;
  logic [127:0] pi_key = '0;
  logic [119:0] pi_nonce = '0;
  logic [7:0]   pi_cnt_init = '0;
  logic [15:0]  pi_num_blk = '0;
  logic         pi_in_valid = 1'b0;
  logic         po_in_ready;
  logic [127:0] pi_in_data = '0;
  logic         po_out_valid;
  logic         pi_out_ready = 1'b0;
  logic [127:0] po_out_data;
  logic         po_aes_start;
  logic [127:0] po_aes_key;
  logic [127:0] po_aes_data;
  logic         pi_aes_done = 1'b0;
  logic [127:0] pi_aes_out = '0;
  logic         po_busy;
  logic         po_msg_done;
  logic [1:0]   po_err;

  aes128_ctr_sched #(.CNT_W(8), .BLK_W(16), .TIMEOUT(64)) dut (
    .pi_clk(pi_clk), .pi_rst_n(pi_rst_n),
    .pi_cfg_valid(pi_cfg_valid), .po_cfg_ready(po_cfg_ready),
    .pi_key(pi_key), .pi_nonce(pi_nonce), .pi_cnt_init(pi_cnt_init),
    .pi_num_blk(pi_num_blk),
    .pi_in_valid(pi_in_valid), .po_in_ready(po_in_ready), .pi_in_data(pi_in_data),
    .po_out_valid(po_out_valid), .pi_out_ready(pi_out_ready), .po_out_data(po_out_data),
    .po_aes_start(po_aes_start), .po_aes_key(po_aes_key), .po_aes_data(po_aes_data),
    .pi_aes_done(pi_aes_done), .pi_aes_out(pi_aes_out),
    .po_busy(po_busy), .po_msg_done(po_msg_done), .po_err(po_err)
  );

  always #5 pi_clk = ~pi_clk;

  int total = 0;
  int bad   = 0;

  // Stand-in block cipher: any fixed keyed mixing function serves here
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] d);
    return {d[100:0], d[127:101]} ^ k ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: answers a start pulse core_delay cycles later unless muted
  int           core_delay = 3;
  bit           core_mute  = 1'b0;
  bit           core_busy  = 1'b0;
  int           core_cnt   = 0;
  logic [127:0] core_res   = '0;
  int           start_cnt  = 0;
  logic [7:0]   seen_q[$];

  always @(posedge pi_clk) begin
    #1;
    pi_aes_done = 1'b0;
    if (core_busy) begin
      if (core_cnt <= 1) begin
        pi_aes_done = 1'b1;
        pi_aes_out  = core_res;
        core_busy   = 1'b0;
      end else begin
        core_cnt--;
      end
    end
    if (po_aes_start) begin
      start_cnt++;
      seen_q.push_back(po_aes_data[7:0]);
      core_res = fake_aes(po_aes_key, po_aes_data);
      if (!core_mute) begin
        core_busy = 1'b1;
        core_cnt  = core_delay;
      end
    end
  end

  logic [127:0] cur_key;
  logic [119:0] cur_nonce;
  logic [7:0]   cur_cnt;
  logic [127:0] sb_q[$];

  task automatic do_cfg(input logic [127:0] k, input logic [119:0] n,
                        input logic [7:0] c, input logic [15:0] nb);
    @(negedge pi_clk);
    check("cfg_ready_idle", po_cfg_ready, 1);
    pi_cfg_valid = 1'b1;
    pi_key = k; pi_nonce = n; pi_cnt_init = c; pi_num_blk = nb;
    cur_key = k; cur_nonce = n; cur_cnt = c;
    @(negedge pi_clk);
    pi_cfg_valid = 1'b0;
    check("start_after_cfg", po_aes_start, 1);
    check("aes_data_at_start", po_aes_data, {n, c});
    check("err_cleared", po_err, 0);
  endtask

  task automatic xfer(input logic [127:0] pt, input int hold, input bit exp_last);
    int w = 0;
    bit stable = 1'b1;
    logic [127:0] held;
    while (!po_in_ready && w < 100) begin
      @(negedge pi_clk);
      w++;
    end
    check("in_ready_wait", po_in_ready, 1);
    if (!po_in_ready) return;
    check("no_valid_with_ready", po_out_valid, 0);
    sb_q.push_back(pt ^ fake_aes(cur_key, {cur_nonce, cur_cnt}));
    pi_in_valid = 1'b1;
    pi_in_data  = pt;
    @(negedge pi_clk);
    pi_in_valid = 1'b0;
    check("out_valid_latency", po_out_valid, 1);
    check("in_ready_dropped", po_in_ready, 0);
    if (hold > 0) begin
      held = po_out_data;
      for (int i = 0; i < hold; i++) begin
        if (i == 5) begin
          pi_cfg_valid = 1'b1;
          pi_key = ~cur_key;
          pi_cnt_init = 8'h77;
          pi_num_blk = 16'd9;
        end
        if (i == 6) pi_cfg_valid = 1'b0;
        @(negedge pi_clk);
        if (po_out_data !== held || !po_out_valid || po_in_ready || po_cfg_ready)
          stable = 1'b0;
      end
      pi_cfg_valid = 1'b0;
      check("backpressure_stable", stable, 1);
    end
    pi_out_ready = 1'b1;
    check("ciphertext", po_out_data, sb_q.pop_front());
    @(negedge pi_clk);
    pi_out_ready = 1'b0;
    check("out_valid_dropped", po_out_valid, 0);
    check("msg_done", po_msg_done, exp_last);
    cur_cnt = cur_cnt + 8'd1;
  endtask

  initial begin
    int s0;
    int n;
    bit quiet;

    // Reset values
    #2 pi_rst_n = 1'b0;
    #1;
    check("rst_cfg_ready", po_cfg_ready, 1);
    check("rst_ctrl", {po_busy, po_in_ready, po_out_valid, po_aes_start, po_msg_done, po_err}, 0);
    check("rst_data", po_out_data ^ po_aes_data ^ po_aes_key, 0);
    @(negedge pi_clk);
    @(negedge pi_clk);
    pi_rst_n = 1'b1;

    // Single block, all-zero plaintext exposes the keystream directly
    seen_q.delete();
    s0 = start_cnt;
    do_cfg(128'h000102030405060708090A0B0C0D0E0F, '0, 8'h00, 16'd1);
    xfer('0, 0, 1'b1);
    check("single_err", po_err, 0);
    @(negedge pi_clk);
    check("single_done_pulse", po_msg_done, 0);
    check("single_starts", start_cnt - s0, 1);

    // Three blocks from counter 05 with slow core
    core_delay = 10;
    seen_q.delete();
    s0 = start_cnt;
    do_cfg(128'hDEADBEEF_00112233_44556677_8899AABB, 120'hA5A5_5A5A_1234, 8'h05, 16'd3);
    xfer(128'h11111111_22222222_33333333_44444444, 0, 1'b0);
    xfer(128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D, 0, 1'b0);
    xfer(128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0, 0, 1'b1);
    check("three_starts", start_cnt - s0, 3);
    check("three_cnt0", seen_q.size() > 0 ? seen_q.pop_front() : 8'hXX, 8'h05);
    check("three_cnt1", seen_q.size() > 0 ? seen_q.pop_front() : 8'hXX, 8'h06);
    check("three_cnt2", seen_q.size() > 0 ? seen_q.pop_front() : 8'hXX, 8'h07);
    check("three_err", po_err, 0);

    // Counter wrap: FE and FF go out, then the message aborts
    core_delay = 2;
    s0 = start_cnt;
    do_cfg(128'h0123456789ABCDEF_0123456789ABCDEF, 120'h77, 8'hFE, 16'd4);
    xfer(128'h1, 0, 1'b0);
    xfer(128'h2, 0, 1'b1);
    check("wrap_err", po_err, 2'b01);
    check("wrap_idle", po_cfg_ready, 1);
    repeat (10) @(negedge pi_clk);
    check("wrap_starts", start_cnt - s0, 2);
    check("wrap_busy", po_busy, 0);

    // Timeout: core never answers
    core_mute = 1'b1;
    do_cfg(128'h55, 120'h66, 8'h10, 16'd2);
    n = 0;
    while (po_busy && n < 300) begin
      n++;
      @(negedge pi_clk);
    end
    check("tmo_busy_cycles", n, 65);
    check("tmo_err", po_err, 2'b10);
    check("tmo_cfg_ready", po_cfg_ready, 1);
    check("tmo_msg_done", po_msg_done, 1);
    core_mute = 1'b0;

    // Backpressure with an ignored mid-message cfg
    core_delay = 4;
    do_cfg(128'hFEEDFACE_0000_1111_2222_3333_4444_5555, 120'h99, 8'h20, 16'd2);
    xfer(128'hABCD, 20, 1'b0);
    xfer(128'h1234, 0, 1'b1);
    check("bp_key_kept", po_aes_key, cur_key);
    check("bp_err", po_err, 0);

    // Zero block count behaves as a single block
    s0 = start_cnt;
    do_cfg(128'h42, 120'h43, 8'h44, 16'd0);
    xfer(128'h45, 0, 1'b1);
    check("zero_blk_starts", start_cnt - s0, 1);

    // Reset during WAIT; the late core answer must be ignored
    core_delay = 10;
    do_cfg(128'h9, 120'h8, 8'h7, 16'd1);
    repeat (3) @(negedge pi_clk);
    pi_rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {po_busy, po_in_ready, po_out_valid, po_aes_start, po_msg_done, po_err}, 0);
    check("mid_rst_data", po_out_data | po_aes_data | po_aes_key, 0);
    check("mid_rst_cfg_ready", po_cfg_ready, 1);
    @(negedge pi_clk);
    @(negedge pi_clk);
    pi_rst_n = 1'b1;
    s0 = start_cnt;
    quiet = 1'b1;
    repeat (15) begin
      @(negedge pi_clk);
      if (po_out_valid || po_in_ready || po_aes_start || po_busy || po_msg_done) quiet = 1'b0;
    end
    check("late_done_ignored", quiet, 1);
    check("late_done_no_start", start_cnt - s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
